fp_csub_pipe: RTL and testbench
===============================

# fp_csub_pipe

Parametrised, fully pipelined IEEE-754 single-precision "constant minus operand" unit: computes K − x for a compile-time constant K. It succeeds the fixed 1.5 − x subtractor in the inverse-square-root Newton step and adds full sign handling, special-value handling, round-to-nearest-even, valid/ready backpressure and a generic sideband delay line. The sideband carries the Newton iterate y alongside x.

## Interface
- `K_BITS`, default `32'h3FC0_0000` (1.5): constant K as an IEEE-754 single bit pattern. Must be normal and finite; elaboration error otherwise.
- `SB_W`, default 32: sideband width, delayed in lockstep with the data path. Minimum 1.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `valid_in` in 1: input beat valid.
- `ready_out` out 1: unit accepts a beat this cycle.
- `x_in` in 32: operand x, single precision.
- `sb_in` in SB_W: sideband, not interpreted.
- `error_in` in 1: upstream error flag.
- `valid_out` out 1: result beat valid.
- `ready_in` in 1: downstream accepts.
- `res_out` out 32: K − x.
- `sb_out` out SB_W: sideband of the same beat.
- `error_out` out 1: error_in OR locally detected error.

## Operation
- Computes K + (−x): the sign of x is inverted, then a standard magnitude add/subtract is performed.
- Input denormals (exp = 0) are treated as ±0, so the result is K exactly.
- x NaN: res = `32'h7FC0_0000`, error = 1.
- x = ±Inf: res = ∓Inf (`FF800000` / `7F800000`), error = 1.
- Stage 1, align:
  - Swap operands so A has the larger magnitude.
  - Form 24-bit significands with the hidden 1, extended by guard, round and sticky bits (27 bits).
  - Right-shift B by the exponent difference. Shifts ≥ 27 fold all of B into sticky.
- Stage 2, add/sub:
  - Same effective sign: add, 28-bit result.
  - Otherwise: A − B.
  - Result sign is the sign of A.
  - Exact zero forces +0.
- Stage 3, normalize and round:
  - Carry-out: shift right 1 and increment the exponent, with sticky OR.
  - Otherwise: shift left by the leading-zero count and decrement the exponent.
  - Round to nearest even on guard/round/sticky. Rounding carry renormalises.
  - Biased exponent ≥ 255: ±Inf, error = 1.
  - Biased exponent ≤ 0: flush to +0, error unchanged.
- Sideband and error_in travel unmodified through all three stages.

## Timing
- Latency is 3 cycles from accept (valid_in & ready_out) to the first cycle of valid_out, when no stall occurs.
- Throughput is 1 beat per cycle.
- Global stall: `en = !valid_out || ready_in`, and `ready_out = en`, combinational.
  - When en = 0, every stage register holds.
  - No beat is dropped or duplicated. Order is preserved.
- A beat with valid_in = 0 enters as a bubble. Bubbles are not collapsed.
- Reset: rst = 1 at a rising edge clears all stage valid bits.
  - valid_out, res_out, sb_out and error_out read 0 from the next cycle.
  - Data in flight is discarded.
  - ready_out = 1 while valid_out = 0.
- Simultaneous rst and valid_in: the beat is not accepted.
- Stalled output: res_out, sb_out and error_out stay stable while valid_out = 1 and ready_in = 0.

## Structure
- Package `fp_pkg`:
  - `float_t` packed struct {sign, exp[7:0], frac[22:0]}.
  - Constants `FP_BIAS = 127`, `FP_QNAN = 32'h7FC0_0000`, `FP_PINF`, `FP_NINF`.
  - Function `fp_is_nan` / `fp_is_inf` / `fp_is_zero_or_denorm`.
  - Stage payload typedefs.
- Sub-module `fp_lzc`: 28-bit leading-zero counter, combinational, 5-bit count. Used in stage 3.
- Top level contains three stage registers, each with its valid bit, plus the shared enable.

## Test plan
(K = 1.5 unless stated.)
- x = `3F000000` (0.5), sb = `DEADBEEF` → res = `3F800000` exactly 3 cycles later, with sb_out = `DEADBEEF` and error_out = 0.
- x = `3FC00000` → res = `00000000`. x = `BF800000` (−1.0) → `40200000` (2.5). x = `00000001` (denorm) → `3FC00000`.
- x = `4B800000` (2^24) → `CB7FFFFE`, a tie rounded to even.
- Special values:
  - x = `7F800000` → `FF800000` with error_out = 1.
  - x = `7FC00001` → `7FC00000` with error_out = 1.
  - x = `40000000` with error_in = 1 → `BF000000` with error_out = 1.
- Backpressure: stream 10 consecutive beats with ready_in held low for 4 cycles mid-stream.
  - ready_out = 0 exactly while valid_out & !ready_in.
  - All 10 results appear in order with matching sideband.
  - Outputs stay stable during the stall.
- Reset mid-stream: assert rst for 1 cycle with 2 beats in flight.
  - valid_out = 0 and all outputs = 0 on the following cycle.
  - Neither beat is emitted.
  - A new beat accepted after reset emerges 3 cycles later.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared single-precision types, constants and helpers
// for the constant-minus-operand pipeline.
package fp_pkg;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
    } float_t;

    localparam int          FP_BIAS = 127;
    localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;
    localparam logic [31:0] FP_PINF = 32'h7F80_0000;
    localparam logic [31:0] FP_NINF = 32'hFF80_0000;

    function automatic logic fp_is_nan(input float_t f);
        return (&f.exp) && (|f.frac);
    endfunction

    function automatic logic fp_is_inf(input float_t f);
        return (&f.exp) && !(|f.frac);
    endfunction

    function automatic logic fp_is_zero_or_denorm(input float_t f);
        return ~|f.exp;
    endfunction

    // aligned operands: A larger magnitude, B shifted with sticky in bit 0
    typedef struct packed {
        logic        valid;
        logic        spec;
        logic [31:0] spec_res;
        logic        err;
        logic        sign;
        logic [7:0]  exp;
        logic        eff_sub;
        logic [26:0] ma;
        logic [26:0] mb;
    } s1_t;

    // raw magnitude sum with carry bit 27
    typedef struct packed {
        logic        valid;
        logic        spec;
        logic [31:0] spec_res;
        logic        err;
        logic        sign;
        logic [7:0]  exp;
        logic        zero;
        logic [27:0] sum;
    } s2_t;

    // final packed result
    typedef struct packed {
        logic        valid;
        logic        err;
        logic [31:0] res;
    } s3_t;

endpackage

// File: rtl/fp_lzc.sv
// 28-bit leading-zero counter, combinational.
// An all-zero input reports 28.
module fp_lzc (
    input  logic [27:0] a,
    output logic [4:0]  cnt
);

    // highest set bit wins, scanning upward
    always_comb begin
        cnt = 5'd28;
        for (int i = 0; i < 28; i++) begin
            if (a[i]) cnt = 5'(27 - i);
        end
    end

endmodule

// File: rtl/fp_csub_pipe.sv
// Three-stage IEEE-754 single K - x unit with
// valid/ready stall, RNE rounding and sideband delay.
module fp_csub_pipe
    import fp_pkg::*;
#(
    parameter logic [31:0] K_BITS = 32'h3FC0_0000,
    parameter int          SB_W   = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_in,
    output logic            ready_out,
    input  logic [31:0]     x_in,
    input  logic [SB_W-1:0] sb_in,
    input  logic            error_in,
    output logic            valid_out,
    input  logic            ready_in,
    output logic [31:0]     res_out,
    output logic [SB_W-1:0] sb_out,
    output logic            error_out
);

    if (K_BITS[30:23] == 8'h00 || K_BITS[30:23] == 8'hFF) begin : g_bad_k
        $error("fp_csub_pipe: K_BITS must be normal and finite");
    end
    if (SB_W < 1) begin : g_bad_sb
        $error("fp_csub_pipe: SB_W must be at least 1");
    end

    localparam float_t K = K_BITS;

    logic            en;
    s1_t             s1_d, s1_q;
    s2_t             s2_d, s2_q;
    s3_t             s3_d, s3_q;
    logic [SB_W-1:0] sb1_q, sb2_q, sb3_q;

    assign en        = !s3_q.valid || ready_in;
    assign ready_out = en;
    assign valid_out = s3_q.valid;
    assign res_out   = s3_q.valid ? s3_q.res : '0;
    assign sb_out    = s3_q.valid ? sb3_q : '0;
    assign error_out = s3_q.valid & s3_q.err;

    float_t      xf, nx, a, b;
    logic [7:0]  d;
    logic [26:0] mb_raw, mb_sh, mask;

    // stage 1: negate x, order by magnitude, align B to A
    always_comb begin
        xf = x_in;
        nx = xf;
        nx.sign = ~xf.sign;
        if ({nx.exp, nx.frac} > {K.exp, K.frac}) begin
            a = nx;
            b = K;
        end else begin
            a = K;
            b = nx;
        end
        d      = a.exp - b.exp;
        mb_raw = {1'b1, b.frac, 3'b000};
        mb_sh  = '0;
        mask   = '0;
        s1_d          = '0;
        s1_d.valid    = valid_in;
        s1_d.err      = error_in;
        s1_d.sign     = a.sign;
        s1_d.exp      = a.exp;
        s1_d.eff_sub  = a.sign ^ b.sign;
        s1_d.ma       = {1'b1, a.frac, 3'b000};
        if (d >= 8'd27) begin
            s1_d.mb = 27'd1;
        end else begin
            mb_sh   = mb_raw >> d;
            mask    = (27'd1 << d) - 27'd1;
            s1_d.mb = {mb_sh[26:1], mb_sh[0] | (|(mb_raw & mask))};
        end
        unique case (1'b1)
            fp_is_nan(xf): begin
                s1_d.spec     = 1'b1;
                s1_d.spec_res = FP_QNAN;
                s1_d.err      = 1'b1;
            end
            fp_is_inf(xf): begin
                s1_d.spec     = 1'b1;
                s1_d.spec_res = xf.sign ? FP_PINF : FP_NINF;
                s1_d.err      = 1'b1;
            end
            fp_is_zero_or_denorm(xf): begin
                s1_d.spec     = 1'b1;
                s1_d.spec_res = K_BITS;
            end
            default: ;
        endcase
    end

    // stage 1 register
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q  <= '0;
            sb1_q <= '0;
        end else if (en) begin
            s1_q  <= s1_d;
            sb1_q <= sb_in;
        end
    end

    logic [27:0] sum;

    // stage 2: magnitude add or subtract, exact zero is +0
    always_comb begin
        if (s1_q.eff_sub) sum = {1'b0, s1_q.ma} - {1'b0, s1_q.mb};
        else              sum = {1'b0, s1_q.ma} + {1'b0, s1_q.mb};
        s2_d          = '0;
        s2_d.valid    = s1_q.valid;
        s2_d.spec     = s1_q.spec;
        s2_d.spec_res = s1_q.spec_res;
        s2_d.err      = s1_q.err;
        s2_d.exp      = s1_q.exp;
        s2_d.sum      = sum;
        s2_d.zero     = ~|sum;
        s2_d.sign     = s1_q.sign & (|sum);
    end

    // stage 2 register
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_q  <= '0;
            sb2_q <= '0;
        end else if (en) begin
            s2_q  <= s2_d;
            sb2_q <= sb1_q;
        end
    end

    logic [4:0]         lz, sh;
    logic [26:0]        m;
    logic signed [9:0]  e;
    logic               rup;
    logic [24:0]        rnd;
    logic [22:0]        frac;

    fp_lzc u_lzc (
        .a   (s2_q.sum),
        .cnt (lz)
    );

    // stage 3: normalise, round to nearest even, pack
    always_comb begin
        sh = lz - 5'd1;
        m  = '0;
        e  = '0;
        if (s2_q.sum[27]) begin
            m = {s2_q.sum[27:2], |s2_q.sum[1:0]};
            e = $signed({2'b00, s2_q.exp}) + 10'sd1;
        end else begin
            m = s2_q.sum[26:0] << sh;
            e = $signed({2'b00, s2_q.exp}) - $signed({5'b00000, sh});
        end
        rup  = m[2] & (m[1] | m[0] | m[3]);
        rnd  = {1'b0, m[26:3]} + {24'b0, rup};
        frac = rnd[22:0];
        if (rnd[24]) begin
            e    = e + 10'sd1;
            frac = rnd[23:1];
        end
        s3_d       = '0;
        s3_d.valid = s2_q.valid;
        s3_d.err   = s2_q.err;
        if (s2_q.spec) begin
            s3_d.res = s2_q.spec_res;
        end else if (s2_q.zero) begin
            s3_d.res = '0;
        end else if (e >= 10'sd255) begin
            s3_d.res = {s2_q.sign, 8'hFF, 23'b0};
            s3_d.err = 1'b1;
        end else if (e <= 10'sd0) begin
            s3_d.res = '0;
        end else begin
            s3_d.res = {s2_q.sign, e[7:0], frac};
        end
    end

    // stage 3 register
    always_ff @(posedge clk) begin
        if (rst) begin
            s3_q  <= '0;
            sb3_q <= '0;
        end else if (en) begin
            s3_q  <= s3_d;
            sb3_q <= sb2_q;
        end
    end

endmodule

// File: tb/tb_fp_csub_pipe.sv
// Randomised self-checking bench for fp_csub_pipe (K = 1.5)
// against a real-arithmetic reference model.
module tb_fp_csub_pipe;

    localparam logic [31:0] K_BITS = 32'h3FC0_0000;

    logic        clk;
    logic        rst;
    logic        valid_in;
    logic        ready_out;
    logic [31:0] x_in;
    logic [31:0] sb_in;
    logic        error_in;
    logic        valid_out;
    logic        ready_in;
    logic [31:0] res_out;
    logic [31:0] sb_out;
    logic        error_out;

    fp_csub_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .x_in      (x_in),
        .sb_in     (sb_in),
        .error_in  (error_in),
        .valid_out (valid_out),
        .ready_in  (ready_in),
        .res_out   (res_out),
        .sb_out    (sb_out),
        .error_out (error_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [31:0] sb;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   ncyc = 0;
    bit   prev_rst = 1'b0;
    bit   lat_chk = 1'b0;
    int   rmode = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    function automatic real sp_val(input logic [31:0] b);
        real v;
        int  ex;
        v  = 1.0 + real'(b[22:0]) / 8388608.0;
        ex = int'(b[30:23]) - 127;
        while (ex > 0) begin v = v * 2.0; ex--; end
        while (ex < 0) begin v = v / 2.0; ex++; end
        return b[31] ? -v : v;
    endfunction

    function automatic logic [31:0] dbl_to_sp(input real r, output logic ovf);
        logic [63:0] d;
        logic [52:0] m;
        logic [24:0] keep;
        logic [28:0] rem;
        int          es;
        ovf = 1'b0;
        if (r == 0.0) return 32'h0;
        d    = $realtobits(r);
        m    = {1'b1, d[51:0]};
        keep = {1'b0, m[52:29]};
        rem  = m[28:0];
        if (rem > 29'h1000_0000 || (rem == 29'h1000_0000 && keep[0]))
            keep = keep + 25'd1;
        es = int'(d[62:52]) - 1023 + 127;
        if (keep[24]) begin
            keep = keep >> 1;
            es++;
        end
        if (es >= 255) begin
            ovf = 1'b1;
            return {d[63], 8'hFF, 23'h0};
        end
        if (es <= 0) return 32'h0;
        return {d[63], 8'(es), keep[22:0]};
    endfunction

    function automatic exp_t model(input logic [31:0] x, input logic [31:0] sb,
                                   input logic e, input int c);
        exp_t r;
        logic ovf;
        r.sb  = sb;
        r.cyc = c;
        r.err = e;
        if (x[30:23] == 8'hFF && x[22:0] != 23'h0) begin
            r.res = 32'h7FC0_0000;
            r.err = 1'b1;
        end else if (x[30:23] == 8'hFF) begin
            r.res = x[31] ? 32'h7F80_0000 : 32'hFF80_0000;
            r.err = 1'b1;
        end else if (x[30:23] == 8'h00) begin
            r.res = K_BITS;
        end else begin
            r.res = dbl_to_sp(sp_val(K_BITS) - sp_val(x), ovf);
            r.err = e | ovf;
        end
        return r;
    endfunction

    function automatic logic [31:0] rand_x();
        int          k;
        logic [7:0]  e;
        logic [22:0] f;
        k = $urandom_range(0, 19);
        f = 23'($urandom);
        case (k)
            0: e = 8'h00;
            1: begin e = 8'hFF; f = 23'h0; end
            2: begin e = 8'hFF; f = f | 23'h1; end
            3: begin
                e = 8'd127;
                f = 23'h40_0000 ^ (23'h1 << $urandom_range(0, 22));
            end
            default: e = 8'(99 + $urandom_range(0, 56));
        endcase
        return {1'($urandom), e, f};
    endfunction

    // ready_in driver, updated just after each rising edge
    always @(posedge clk) begin
        #2;
        case (rmode)
            0:       ready_in = 1'b1;
            1:       ready_in = ($urandom_range(0, 3) != 0);
            default: ready_in = 1'b0;
        endcase
    end

    // scoreboard and protocol checks on the falling edge
    always @(negedge clk) begin
        ncyc++;
        chk("ready_out", {63'h0, ready_out}, {63'h0, !(valid_out && !ready_in)});
        if (prev_rst) begin
            chk("rst_valid", {63'h0, valid_out}, 64'h0);
            chk("rst_res", {32'h0, res_out}, 64'h0);
            chk("rst_sb", {32'h0, sb_out}, 64'h0);
            chk("rst_err", {63'h0, error_out}, 64'h0);
        end else if (valid_out) begin
            if (q.size() == 0) begin
                chk("unexpected_beat", 64'h1, 64'h0);
            end else begin
                chk("res", {32'h0, res_out}, {32'h0, q[0].res});
                chk("sb", {32'h0, sb_out}, {32'h0, q[0].sb});
                chk("err", {63'h0, error_out}, {63'h0, q[0].err});
                if (ready_in) begin
                    if (lat_chk) chk("latency", 64'(ncyc - q[0].cyc), 64'd3);
                    void'(q.pop_front());
                end
            end
        end
        if (rst) q.delete();
        else if (valid_in && ready_out)
            q.push_back(model(x_in, sb_in, error_in, ncyc));
        prev_rst = rst;
    end

    task automatic send(input logic [31:0] x, input logic [31:0] sb, input logic e);
        int n;
        n        = 0;
        valid_in = 1'b1;
        x_in     = x;
        sb_in    = sb;
        error_in = e;
        @(negedge clk);
        while (!ready_out && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!ready_out) chk("accept_timeout", 64'h0, 64'h1);
        @(posedge clk);
        #1;
        valid_in = 1'b0;
    endtask

    task automatic idle(input int n);
        valid_in = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [31:0] dx [9];
    logic        de [9];

    initial begin
        rst      = 1'b1;
        valid_in = 1'b0;
        x_in     = '0;
        sb_in    = '0;
        error_in = 1'b0;
        ready_in = 1'b1;
        dx = '{32'h3F00_0000, 32'h3FC0_0000, 32'hBF80_0000, 32'h0000_0001,
               32'h4B80_0000, 32'h7F80_0000, 32'h7FC0_0001, 32'h4000_0000,
               32'h3FBF_FFFF};
        de = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        lat_chk = 1'b1;
        for (int i = 0; i < 9; i++)
            send(dx[i], (i == 0) ? 32'hDEAD_BEEF : $urandom(), de[i]);
        idle(6);
        lat_chk = 1'b0;

        rmode = 1;
        repeat (300) begin
            if ($urandom_range(0, 4) == 0) idle(1);
            send(rand_x(), $urandom(), ($urandom_range(0, 7) == 0));
        end
        rmode = 0;
        idle(8);

        fork
            begin
                for (int i = 0; i < 10; i++)
                    send(rand_x(), 32'hA000_0000 + 32'(i), 1'b0);
            end
            begin
                repeat (6) @(posedge clk);
                rmode = 2;
                repeat (4) @(posedge clk);
                rmode = 0;
            end
        join
        idle(8);

        send(32'h3F00_0000, 32'h1111_1111, 1'b0);
        send(32'h4000_0000, 32'h2222_2222, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        lat_chk = 1'b1;
        send(32'hBF80_0000, 32'h3333_3333, 1'b0);
        idle(6);

        begin
            int n;
            n = 0;
            while (q.size() != 0 && n < 200) begin
                @(posedge clk);
                n++;
            end
            chk("drain_empty", 64'(q.size()), 64'h0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
